// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, instruction encodings and control codes for the CPU controller.
package cpu_pkg;
    typedef enum logic [2:0] {S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG} state_t;
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: splits the instruction register into fields and sign-extends both immediates.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [15:0]   i_ir,
    output logic [2:0]    o_opcode,
    output logic [1:0]    o_op,
    output logic [2:0]    o_rn,
    output logic [2:0]    o_rd,
    output logic [1:0]    o_sh,
    output logic [2:0]    o_rm,
    output logic [DW-1:0] o_sximm8,
    output logic [DW-1:0] o_sximm5
);
    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = {{(DW-8){i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5 = {{(DW-5){i_ir[4]}}, i_ir[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: IR, multi-cycle control FSM and status flags of the RISC CPU.
// Define CTRL_FLAGS_ALL_EN to update Z/N/V on every ALU-class instruction, not only CMP.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load,
    input  logic [15:0]   in,
    input  logic [2:0]    zno,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic          Z,
    output logic          N,
    output logic          V
);
    state_t      r_state;
    logic [15:0] r_ir;
    logic [2:0]  r_flags;
    logic [2:0]  w_opc, w_rn, w_rd, w_rm;
    logic [1:0]  w_op;
    logic        w_cmp, w_loads;

    instr_decoder #(.DW(DW)) u_dec (
        .i_ir(r_ir), .o_opcode(w_opc), .o_op(w_op), .o_rn(w_rn), .o_rd(w_rd),
        .o_sh(shift), .o_rm(w_rm), .o_sximm8(sximm8), .o_sximm5(sximm5)
    );

    assign w_cmp = w_opc == OPC_ALU && w_op == OP_CMP;
`ifdef CTRL_FLAGS_ALL_EN
    assign w_loads = r_state == S_EXEC && w_opc == OPC_ALU;
`else
    assign w_loads = r_state == S_EXEC && w_cmp;
`endif

    // Strobes are masked by reset so an aborted instruction cannot write in the reset cycle
    assign w        = r_state == S_WAIT;
    assign readnum  = RW'(r_state == S_GETA ? w_rn : r_state == S_GETB ? w_rm : 3'd0);
    assign writenum = RW'(r_state == S_WIMM ? w_rn : r_state == S_WREG ? w_rd : 3'd0);
    assign write    = !reset && (r_state == S_WIMM || r_state == S_WREG);
    assign loada    = !reset && r_state == S_GETA;
    assign loadb    = !reset && r_state == S_GETB;
    assign loadc    = !reset && r_state == S_EXEC && !w_cmp;
    assign loads    = !reset && w_loads;
    assign asel     = r_state == S_EXEC && w_opc == OPC_MOV;
    assign bsel     = 1'b0;
    assign vsel     = r_state == S_WIMM ? VSEL_IMM : VSEL_C;
    assign ALUop    = r_state == S_EXEC && w_opc == OPC_ALU ? w_op : ALU_ADD;
    assign {Z, N, V} = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
            r_flags <= '0;
        end else begin
            if (w_loads) r_flags <= zno;
            case (r_state)
                S_WAIT: begin
                    if (load) r_ir <= in;
                    if (s) r_state <= S_DECODE;
                end
                S_DECODE: r_state <= (w_opc == OPC_MOV && w_op == OP_MOVI) ? S_WIMM :
                                     ((w_opc == OPC_MOV && w_op == OP_MOVR) ||
                                      (w_opc == OPC_ALU && w_op == OP_MVN)) ? S_GETB :
                                     (w_opc == OPC_ALU) ? S_GETA : S_WAIT;
                S_GETA:   r_state <= S_GETB;
                S_GETB:   r_state <= S_EXEC;
                S_EXEC:   r_state <= w_cmp ? S_WAIT : S_WREG;
                default:  r_state <= S_WAIT;
            endcase
        end
    end
endmodule
